// File: rtl/c1_pkg.sv
// Shared constants and types for the C1 capture FIFO.
// No logic; C1_CAP_PARITY_EN selects whether a stored entry carries a parity bit.
// The entry typedef and parity width follow that macro so storage and ports agree.
package c1_pkg;

  localparam int C1_SIZE      = 5;
  localparam int C1_CAP_DEPTH = 4;

`ifdef C1_CAP_PARITY_EN
  localparam int C1_CAP_PAR_W = 1;
  typedef struct packed {
    logic               par;
    logic [C1_SIZE-1:0] dat;
  } c1_entry_t;
`else
  localparam int C1_CAP_PAR_W = 0;
  typedef struct packed {
    logic [C1_SIZE-1:0] dat;
  } c1_entry_t;
`endif

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int c1_occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/c1_cap_mem.sv
// Entry storage for the capture FIFO: one write port, one asynchronous read port.
// Latency: write lands on the rising edge, read is combinational from the address.
// No backpressure and no reset; validity is owned by the pointers and count above.
module c1_cap_mem #(
  parameter int W     = 5,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Store the incoming entry at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/c1_capture_fifo.sv
// Captures the C1 mux word F into a first-word-fall-through FIFO; optional parity via C1_CAP_PARITY_EN.
// Latency: a word pushed on edge N is presented at out_data right after edge N.
// Backpressure: f_ready = not full, from registered state only; producer holds its word while low.
module c1_capture_fifo
  import c1_pkg::*;
#(
  parameter int SIZE  = C1_SIZE,
  parameter int DEPTH = C1_CAP_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SIZE-1:0]             f_in,
  input  logic                        f_valid,
  output logic                        f_ready,
  input  logic                        clr,
  output logic [SIZE-1:0]             out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [c1_occ_w(DEPTH)-1:0]  count
`ifdef C1_CAP_PARITY_EN
  ,
  output logic                        out_parity
`endif
);

  localparam int CNT_W = c1_occ_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = SIZE + C1_CAP_PAR_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [ENT_W-1:0] wr_ent, rd_ent;

  // EMPTY / PARTIAL / FULL are implied by count; no separate state register.
  assign f_ready   = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = f_valid & f_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

`ifdef C1_CAP_PARITY_EN
  // Parity is computed once at push so the head word carries its own check bit.
  assign wr_ent     = {^f_in, f_in};
  assign out_data   = rd_ent[SIZE-1:0];
  // Gated by out_valid so the stale-memory bit never shows while empty.
  assign out_parity = out_valid & rd_ent[SIZE];
`else
  assign wr_ent   = f_in;
  assign out_data = rd_ent;
`endif

  // Next-state for pointers and occupancy; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  c1_cap_mem #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push & ~clr),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_ent),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_ent)
  );

endmodule

// File: tb/tb_c1_capture_fifo.sv
// Bench for c1_capture_fifo: directed steps plus random traffic against a queue model.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Parity checks are compiled in only when C1_CAP_PARITY_EN is defined.
module tb_c1_capture_fifo;

  localparam int SIZE  = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [SIZE-1:0]  f_in;
  logic             f_valid;
  logic             f_ready;
  logic             clr;
  logic [SIZE-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count;
`ifdef C1_CAP_PARITY_EN
  logic             out_parity;
`endif

  int total = 0;
  int bad   = 0;

  // Reference: the FIFO contents in arrival order.
  logic [SIZE-1:0] mq[$];

  c1_capture_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_in      (f_in),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef C1_CAP_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".f_ready"}, 32'(f_ready), 32'(mq.size() != DEPTH));
    if (mq.size() != 0) chk({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
`ifdef C1_CAP_PARITY_EN
    chk({tag, ".out_parity"}, 32'(out_parity), (mq.size() != 0) ? 32'(^mq[0]) : 32'd0);
`endif
  endtask

  // One clock cycle with the given inputs; model decides acceptance from its own occupancy.
  task automatic cyc(input string tag, input logic fv, input logic [SIZE-1:0] fd,
                     input logic ordy, input logic cl);
    bit do_push, do_pop;
    f_valid   = fv;
    f_in      = fd;
    out_ready = ordy;
    clr       = cl;
    do_push   = fv && (mq.size() < DEPTH);
    do_pop    = ordy && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (cl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(fd);
    end
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; f_in = '0; f_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    #2;
    check_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("idle", 1'b0, 5'h00, 1'b0, 1'b0);

    // Three words held, then asynchronous reset mid-cycle.
    cyc("pre_rst", 1'b1, 5'h0A, 1'b0, 1'b0);
    cyc("pre_rst", 1'b1, 5'h0B, 1'b0, 1'b0);
    cyc("pre_rst", 1'b1, 5'h0C, 1'b0, 1'b0);
    f_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    check_state("async_rst");
    #1;
    rst_n = 1'b1;
    cyc("post_rst", 1'b0, 5'h00, 1'b0, 1'b0);

    // Fill with the consumer stalled, then offer a fifth word.
    cyc("fill", 1'b1, 5'h01, 1'b0, 1'b0);
    cyc("fill", 1'b1, 5'h02, 1'b0, 1'b0);
    cyc("fill", 1'b1, 5'h03, 1'b0, 1'b0);
    cyc("fill", 1'b1, 5'h04, 1'b0, 1'b0);
    chk("full.count", 32'(count), 32'd4);
    chk("full.f_ready", 32'(f_ready), 32'd0);
    cyc("overfill", 1'b1, 5'h1F, 1'b0, 1'b0);
    chk("overfill.count", 32'(count), 32'd4);
    chk("overfill.head", 32'(out_data), 32'h01);

    // Drain in order.
    for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 5'h00, 1'b1, 1'b0);
    chk("drained.out_valid", 32'(out_valid), 32'd0);

    // Hold at count 2 with simultaneous push and pop; pointers wrap.
    cyc("pp_fill", 1'b1, 5'h11, 1'b0, 1'b0);
    cyc("pp_fill", 1'b1, 5'h12, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc("pushpop", 1'b1, 5'(5'h13 + i), 1'b1, 1'b0);
      chk("pushpop.count", 32'(count), 32'd2);
    end
    for (int i = 0; i < 2; i++) cyc("pp_drain", 1'b0, 5'h00, 1'b1, 1'b0);

    // Flush at count 3 with a push in the same cycle.
    cyc("clr_fill", 1'b1, 5'h05, 1'b0, 1'b0);
    cyc("clr_fill", 1'b1, 5'h06, 1'b0, 1'b0);
    cyc("clr_fill", 1'b1, 5'h07, 1'b0, 1'b0);
    cyc("clr", 1'b1, 5'h08, 1'b0, 1'b1);
    chk("clr.count", 32'(count), 32'd0);
    chk("clr.out_valid", 32'(out_valid), 32'd0);
    cyc("post_clr", 1'b0, 5'h00, 1'b0, 1'b0);

`ifdef C1_CAP_PARITY_EN
    cyc("par1", 1'b1, 5'b10110, 1'b0, 1'b0);
    chk("par1.out_parity", 32'(out_parity), 32'd1);
    cyc("par_pop", 1'b0, 5'h00, 1'b1, 1'b0);
    cyc("par0", 1'b1, 5'b10100, 1'b0, 1'b0);
    chk("par0.out_parity", 32'(out_parity), 32'd0);
    cyc("par_pop", 1'b0, 5'h00, 1'b1, 1'b0);
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", 1'($urandom_range(0, 2) != 0), 5'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
